// File: rtl/nv_nvdla_rubik_pfifo_pkg.sv
// nv_nvdla_rubik_pfifo_pkg: default sizing and the write-limit decode shared by the RUBIK queues
package nv_nvdla_rubik_pfifo_pkg;
  localparam int RUBIK_PFIFO_DW = 11;
  localparam int RUBIK_PFIFO_DEPTH = 256;
  localparam int RUBIK_PFIFO_AFULL = 224;
  // a programmed limit of 0 or beyond the RAM size means "use the whole RAM"
  function automatic int pfifo_lim(input int wr_limit, input int depth);
    return (wr_limit == 0 || wr_limit > depth) ? depth : wr_limit;
  endfunction
endpackage

// File: rtl/nv_nvdla_rubik_pfifo_if.sv
// nv_nvdla_rubik_pfifo_if: valid/ready payload ports plus flush, limit and occupancy of one RUBIK fifo
interface nv_nvdla_rubik_pfifo_if import nv_nvdla_rubik_pfifo_pkg::*; #(
  parameter int DW = RUBIK_PFIFO_DW,
  parameter int DEPTH = RUBIK_PFIFO_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic idata_pvld;
  logic idata_prdy;
  logic [DW-1:0] idata_pd;
  logic odata_pvld;
  logic odata_prdy;
  logic [DW-1:0] odata_pd;
  logic flush;
  logic [CW-1:0] wr_limit;
  logic [CW-1:0] wr_count;
  logic almost_full;
  modport master (
    output idata_pvld, idata_pd, odata_prdy, flush, wr_limit,
    input idata_prdy, odata_pvld, odata_pd, wr_count, almost_full
  );
  modport slave (
    input idata_pvld, idata_pd, odata_prdy, flush, wr_limit,
    output idata_prdy, odata_pvld, odata_pd, wr_count, almost_full
  );
endinterface

// File: rtl/nv_nvdla_rubik_pfifo_ram.sv
// nv_nvdla_rubik_pfifo_ram: 1R1W storage array with registered read data
module nv_nvdla_rubik_pfifo_ram #(
  parameter int DW = 11,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input logic nvdla_core_clk,
  input logic [AW-1:0] ra,
  input logic re,
  input logic ore,
  output logic [DW-1:0] dout,
  input logic [AW-1:0] wa,
  input logic we,
  input logic [DW-1:0] di,
  input logic [31:0] pwrbus_ram_pd
);
  logic [DW-1:0] mem [DEPTH];
  logic unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;
  // array write port
  always_ff @(posedge nvdla_core_clk)
    if (we) mem[wa] <= di;
  // read data register holds its value unless a read is issued on an enabled cycle
  always_ff @(posedge nvdla_core_clk)
    if (re && ore) dout <= mem[ra];
endmodule

// File: rtl/nv_nvdla_rubik_pfifo.sv
// nv_nvdla_rubik_pfifo: parametrised valid/ready fifo with flush, runtime write limit and almost-full
module nv_nvdla_rubik_pfifo import nv_nvdla_rubik_pfifo_pkg::*; #(
  parameter int DW = RUBIK_PFIFO_DW,
  parameter int DEPTH = RUBIK_PFIFO_DEPTH,
  parameter int AFULL = RUBIK_PFIFO_AFULL
) (
  input logic nvdla_core_clk,
  input logic nvdla_core_rstn,
  nv_nvdla_rubik_pfifo_if.slave io,
  input logic [31:0] pwrbus_ram_pd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic ipipe_vld;
  logic [DW-1:0] ipipe_pd;
  logic [AW-1:0] wr_adr, rd_adr, ram_ra;
  logic [CW-1:0] count, count_next, lim, rd_count;
  logic prdy, prdy_next, pvld, af, pop_d;
  logic accept, pop, load, ram_we, core_en;
  assign accept = io.idata_pvld && prdy;
  assign pop = pvld && io.odata_prdy;
  assign lim = CW'(pfifo_lim(int'(io.wr_limit), DEPTH));
  // the write side learns about a pop one cycle late, so the count stays conservative
  assign count_next = count + CW'(accept) - CW'(pop_d);
  assign prdy_next = !(count_next >= lim);
  // rd_count includes the entry on the output, so a pop needs a second entry to refill
  assign load = pop ? (rd_count >= CW'(2)) : (!pvld && rd_count != '0);
  assign ram_ra = pop ? rd_adr + AW'(1) : rd_adr;
  assign ram_we = ipipe_vld && !io.flush;
  assign core_en = accept || pop || pop_d || ipipe_vld || load || (prdy_next != prdy) || io.flush;
  assign io.idata_prdy = prdy;
  assign io.odata_pvld = pvld;
  assign io.wr_count = count;
  assign io.almost_full = af;
  // input handshake register: a beat accepted now is written to the RAM next cycle
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) ipipe_vld <= 1'b0;
    else if (core_en) ipipe_vld <= accept && !io.flush;
  // payload of the input register needs no reset, it is qualified by ipipe_vld
  always_ff @(posedge nvdla_core_clk)
    if (accept) ipipe_pd <= io.idata_pd;
  // write side: occupancy, ready, almost-full, delayed pop and write pointer
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      count <= '0;
      prdy <= 1'b1;
      af <= 1'b0;
      pop_d <= 1'b0;
      wr_adr <= '0;
    end else if (io.flush) begin
      count <= '0;
      prdy <= 1'b1;
      af <= 1'b0;
      pop_d <= 1'b0;
      wr_adr <= '0;
    end else if (core_en) begin
      count <= count_next;
      prdy <= prdy_next;
      af <= count_next >= CW'(AFULL);
      pop_d <= pop;
      wr_adr <= wr_adr + AW'(ipipe_vld);
    end
  // read side: entries resident in RAM, read pointer and output valid
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      rd_count <= '0;
      rd_adr <= '0;
      pvld <= 1'b0;
    end else if (io.flush) begin
      rd_count <= '0;
      rd_adr <= '0;
      pvld <= 1'b0;
    end else if (core_en) begin
      rd_count <= rd_count + CW'(ipipe_vld) - CW'(pop);
      rd_adr <= rd_adr + AW'(pop);
      pvld <= load || (pvld && !pop);
    end
  a_count_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    count <= CW'(DEPTH) && rd_count <= CW'(DEPTH));
  nv_nvdla_rubik_pfifo_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .nvdla_core_clk(nvdla_core_clk),
    .ra(ram_ra),
    .re(load),
    .ore(core_en),
    .dout(io.odata_pd),
    .wa(wr_adr),
    .we(ram_we),
    .di(ipipe_pd),
    .pwrbus_ram_pd(pwrbus_ram_pd)
  );
endmodule

// File: tb/tb_nv_nvdla_rubik_pfifo.sv
// tb_nv_nvdla_rubik_pfifo: directed checks of the RUBIK fifo at DEPTH=8, AFULL=6
`timescale 1ns/1ps
module tb_nv_nvdla_rubik_pfifo;
  localparam int DW = 11;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;
  int lim_q = DEPTH;
  logic [DW-1:0] exp_q[$];
  always #5 clk = ~clk;
  nv_nvdla_rubik_pfifo_if #(.DW(DW), .DEPTH(DEPTH)) io();
  nv_nvdla_rubik_pfifo #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rstn(rstn),
    .io(io),
    .pwrbus_ram_pd(32'd0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag);
    int t = 0;
    io.odata_prdy = 1'b1;
    while ((io.wr_count != 0 || io.odata_pvld) && t < 100) begin
      step();
      t++;
    end
    io.odata_prdy = 1'b0;
    chk(tag, io.wr_count, 0);
    chk({tag, "_q"}, exp_q.size(), 0);
  endtask
  // scoreboard and flag model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      lim_q = DEPTH;
    end else begin
      chk("prdy_vs_lim", io.idata_prdy, io.wr_count < lim_q);
      chk("afull_vs_count", io.almost_full, io.wr_count >= AFULL);
      if (io.odata_pvld && io.odata_prdy) begin
        n_pop++;
        chk("pop_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("order", io.odata_pd, exp_q.pop_front());
      end
      if (io.flush) exp_q.delete();
      else if (io.idata_pvld && io.idata_prdy) exp_q.push_back(io.idata_pd);
      lim_q = (io.wr_limit == 0 || io.wr_limit > DEPTH) ? DEPTH : int'(io.wr_limit);
    end
  end
  initial begin
    int p0, t, sent;
    bit seen;
    io.idata_pvld = 1'b0;
    io.idata_pd = '0;
    io.odata_prdy = 1'b0;
    io.flush = 1'b0;
    io.wr_limit = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("rst_prdy", io.idata_prdy, 1);
    chk("rst_pvld", io.odata_pvld, 0);
    chk("rst_count", io.wr_count, 0);
    chk("rst_afull", io.almost_full, 0);
    // single beat latency into an empty fifo
    io.idata_pvld = 1'b1;
    io.idata_pd = 11'h05A;
    step();
    io.idata_pvld = 1'b0;
    chk("lat_n1_pvld", io.odata_pvld, 0);
    chk("lat_n1_count", io.wr_count, 1);
    step();
    chk("lat_n2_pvld", io.odata_pvld, 0);
    step();
    chk("lat_n3_pvld", io.odata_pvld, 1);
    chk("lat_n3_pd", io.odata_pd, 11'h05A);
    io.odata_prdy = 1'b1;
    step();
    io.odata_prdy = 1'b0;
    chk("lat_n4_pvld", io.odata_pvld, 0);
    chk("lat_n4_count", io.wr_count, 1);
    step();
    chk("lat_n5_count", io.wr_count, 0);
    // fill to DEPTH, the ninth beat must wait
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_prdy_open", io.idata_prdy, 1);
      chk("af_fill", io.almost_full, i >= AFULL);
      io.idata_pvld = 1'b1;
      io.idata_pd = DW'(11'h100 + i);
      step();
    end
    io.idata_pd = 11'h1FF;
    chk("full_prdy", io.idata_prdy, 0);
    chk("full_count", io.wr_count, 8);
    chk("full_afull", io.almost_full, 1);
    repeat (3) step();
    chk("full_hold_prdy", io.idata_prdy, 0);
    chk("full_hold_count", io.wr_count, 8);
    chk("stall_pd", io.odata_pd, 11'h100);
    p0 = n_pop;
    io.odata_prdy = 1'b1;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 20) begin
      if (io.idata_prdy) seen = 1'b1;
      step();
      t++;
    end
    io.idata_pvld = 1'b0;
    chk("full_ninth_taken", seen, 1);
    drain("full_drain");
    chk("full_pops", n_pop - p0, 9);
    // lowered limit with six stored, then limit 0 restores full capacity
    for (int i = 0; i < 6; i++) begin
      io.idata_pvld = 1'b1;
      io.idata_pd = DW'(11'h200 + i);
      step();
    end
    io.idata_pvld = 1'b0;
    io.wr_limit = 4'd4;
    step();
    chk("lim_count6", io.wr_count, 6);
    chk("lim_prdy_low", io.idata_prdy, 0);
    io.idata_pvld = 1'b1;
    io.idata_pd = 11'h280;
    io.odata_prdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (io.idata_prdy) begin
        seen = 1'b1;
        chk("lim_open_below", io.wr_count < 4, 1);
      end
      step();
      if (io.idata_pvld && !io.idata_prdy) io.idata_pd = io.idata_pd;
      io.idata_pd = io.idata_pd + 1'b1;
    end
    chk("lim_reopened", seen, 1);
    io.idata_pvld = 1'b0;
    io.odata_prdy = 1'b0;
    io.wr_limit = '0;
    step();
    t = 0;
    while (io.idata_prdy && t < 30) begin
      io.idata_pvld = 1'b1;
      io.idata_pd = DW'(11'h2C0 + t);
      step();
      t++;
    end
    io.idata_pvld = 1'b0;
    chk("lim0_full_count", io.wr_count, 8);
    drain("lim_drain");
    // flush with five stored and a push in the flush cycle
    for (int i = 0; i < 5; i++) begin
      io.idata_pvld = 1'b1;
      io.idata_pd = DW'(11'h300 + i);
      step();
    end
    io.idata_pd = 11'h3EE;
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    io.idata_pvld = 1'b0;
    chk("flush_count", io.wr_count, 0);
    chk("flush_pvld", io.odata_pvld, 0);
    chk("flush_prdy", io.idata_prdy, 1);
    chk("flush_afull", io.almost_full, 0);
    step();
    chk("flush_pvld_n2", io.odata_pvld, 0);
    step();
    chk("flush_pvld_n3", io.odata_pvld, 0);
    chk("flush_count_n3", io.wr_count, 0);
    io.idata_pvld = 1'b1;
    io.idata_pd = 11'h3A5;
    step();
    io.idata_pvld = 1'b0;
    t = 0;
    while (!io.odata_pvld && t < 10) begin
      step();
      t++;
    end
    chk("flush_fresh_pvld", io.odata_pvld, 1);
    chk("flush_fresh_pd", io.odata_pd, 11'h3A5);
    drain("flush_drain");
    // random stream across many pointer wraps
    p0 = n_pop;
    sent = 0;
    t = 0;
    while (n_pop - p0 < 1000 && t < 20000) begin
      io.idata_pvld = (sent < 1000) && ($urandom_range(1) == 1);
      io.idata_pd = DW'($urandom);
      if (io.idata_pvld && io.idata_prdy) sent++;
      io.odata_prdy = $urandom_range(1) == 1;
      step();
      t++;
    end
    io.idata_pvld = 1'b0;
    io.odata_prdy = 1'b0;
    chk("stream_sent", sent, 1000);
    chk("stream_pops", n_pop - p0, 1000);
    chk("stream_q", exp_q.size(), 0);
    // asynchronous reset in the middle of a burst
    io.odata_prdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      io.idata_pvld = 1'b1;
      io.idata_pd = DW'(11'h400 + i);
      step();
    end
    #2 rstn = 1'b0;
    #1;
    chk("arst_prdy", io.idata_prdy, 1);
    chk("arst_pvld", io.odata_pvld, 0);
    chk("arst_count", io.wr_count, 0);
    chk("arst_afull", io.almost_full, 0);
    io.idata_pvld = 1'b0;
    io.odata_prdy = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("arst_post_pvld", io.odata_pvld, 0);
    io.idata_pvld = 1'b1;
    io.idata_pd = 11'h4AB;
    step();
    io.idata_pvld = 1'b0;
    t = 0;
    while (!io.odata_pvld && t < 10) begin
      step();
      t++;
    end
    chk("arst_fresh_pd", io.odata_pd, 11'h4AB);
    drain("arst_drain");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
